// File: rtl/instr_encoder.sv
// RV32I instruction encoder with a one-entry registered output stage and a word-address counter.
// Define INSTR_ENC_RANGE_CHECK_EN to drop out-of-range immediates (error=1) instead of truncating them.
module instr_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  kind,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic [31:0] addr,
  output logic        error,
  input  logic        clr_err
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned KINDW = 4;
  localparam int unsigned OPW   = 7;

  localparam logic [KINDW-1:0] K_LW    = KINDW'(0);
  localparam logic [KINDW-1:0] K_SW    = KINDW'(1);
  localparam logic [KINDW-1:0] K_R     = KINDW'(2);
  localparam logic [KINDW-1:0] K_IALU  = KINDW'(3);
  localparam logic [KINDW-1:0] K_BR    = KINDW'(4);
  localparam logic [KINDW-1:0] K_JAL   = KINDW'(5);
  localparam logic [KINDW-1:0] K_JALR  = KINDW'(6);
  localparam logic [KINDW-1:0] K_LUI   = KINDW'(7);
  localparam logic [KINDW-1:0] K_AUIPC = KINDW'(8);
  localparam logic [KINDW-1:0] K_NULL  = KINDW'(15);

  localparam logic [OPW-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPW-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPW-1:0] OP_R      = 7'b0110011;
  localparam logic [OPW-1:0] OP_IALU   = 7'b0010011;
  localparam logic [OPW-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPW-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPW-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPW-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPW-1:0] OP_AUIPC  = 7'b0010111;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            err_q, err_d;

  logic [XLEN-1:0] enc_word;
  logic            kind_ok;
  logic            imm_ok;
  logic            shift_op;
  logic            accept;
  logic            handshake;

  assign shift_op  = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign in_ready  = !valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign handshake = valid_q && out_ready;

  // Field placement per RV32I format; unused fields stay zero.
  always_comb begin
    enc_word = '0;
    kind_ok  = 1'b1;
    case (kind)
      K_LW:    enc_word = {imm[11:0], rs1, 3'b010, rd, OP_LOAD};
      K_SW:    enc_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
      K_R:     enc_word = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, OP_R};
      K_IALU:  enc_word = shift_op ? {1'b0, funct7b5, 5'b00000, imm[4:0], rs1, funct3, rd, OP_IALU}
                                   : {imm[11:0], rs1, funct3, rd, OP_IALU};
      K_BR:    enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
      K_JAL:   enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      K_JALR:  enc_word = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
      K_LUI:   enc_word = {imm[31:12], rd, OP_LUI};
      K_AUIPC: enc_word = {imm[31:12], rd, OP_AUIPC};
      K_NULL:  enc_word = '0;
      default: kind_ok  = 1'b0;
    endcase
  end

`ifdef INSTR_ENC_RANGE_CHECK_EN
  // Sign-extension checks: the bits above each field must all equal the field's sign bit.
  logic fits_i, fits_b, fits_j;
  assign fits_i = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign fits_b = ((imm[31:12] == '0) || (imm[31:12] == '1)) && !imm[0];
  assign fits_j = ((imm[31:20] == '0) || (imm[31:20] == '1)) && !imm[0];

  always_comb begin
    imm_ok = 1'b1;
    case (kind)
      K_LW, K_SW, K_JALR: imm_ok = fits_i;
      K_IALU:             imm_ok = shift_op ? (imm[31:5] == '0) : fits_i;
      K_BR:               imm_ok = fits_b;
      K_JAL:              imm_ok = fits_j;
      K_LUI, K_AUIPC:     imm_ok = (imm[11:0] == '0);
      default:            imm_ok = 1'b1;
    endcase
  end
`else
  assign imm_ok = 1'b1;
`endif

  // Output register, address counter and sticky error; a new error wins over clr_err.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    err_d   = err_q;
    if (handshake) begin
      valid_d = 1'b0;
      addr_d  = addr_q + XLEN'(4);
    end
    if (accept && kind_ok && imm_ok) begin
      valid_d = 1'b1;
      instr_d = enc_word;
    end
    if (clr_err) begin
      err_d = 1'b0;
    end
    if (accept && !(kind_ok && imm_ok)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = valid_q;
  assign instr     = instr_q;
  assign addr      = addr_q;
  assign error     = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: fixed vectors, hand sequences and random traffic vs a model.
module tb_instr_encoder;

`ifdef INSTR_ENC_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  kind;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [31:0] addr;
  logic        error;
  logic        clr_err;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .kind(kind), .funct3(funct3), .funct7b5(funct7b5), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
    .addr(addr), .error(error), .clr_err(clr_err)
  );

  int checks = 0;
  int failures = 0;

  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_addr;
  logic        m_err;

  typedef struct {
    logic [3:0]  k;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  d;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [31:0] im;
    logic [31:0] exp;
    bit          drop;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference encoding built from field arithmetic; bit 32 = instruction is kept.
  function automatic logic [32:0] ref_encode(input logic [3:0] k, input logic [2:0] f3,
                                             input logic f7, input logic [4:0] d,
                                             input logic [4:0] s1, input logic [4:0] s2,
                                             input logic [31:0] im);
    logic [31:0] w;
    logic [31:0] regs;
    int signed   v;
    bit          known;
    bit          rng;
    bit          shift;
    v     = $signed(im);
    regs  = (32'(d) << 7) | (32'(s1) << 15);
    shift = (f3 == 3'd1) || (f3 == 3'd5);
    known = 1'b1;
    rng   = 1'b1;
    w     = 32'h0;
    case (k)
      4'd0: begin w = ((im & 32'hFFF) << 20) | regs | (32'd2 << 12) | 32'h03; rng = (v >= -2048 && v <= 2047); end
      4'd1: begin
        w = (((im >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | (32'(s1) << 15) | (32'd2 << 12) |
            ((im & 32'h1F) << 7) | 32'h23;
        rng = (v >= -2048 && v <= 2047);
      end
      4'd2: w = (32'(f7) << 30) | (32'(s2) << 20) | regs | (32'(f3) << 12) | 32'h33;
      4'd3: begin
        if (shift) begin
          w = (32'(f7) << 30) | ((im & 32'h1F) << 20) | regs | (32'(f3) << 12) | 32'h13;
          rng = ((im >> 5) == 32'h0);
        end else begin
          w = ((im & 32'hFFF) << 20) | regs | (32'(f3) << 12) | 32'h13;
          rng = (v >= -2048 && v <= 2047);
        end
      end
      4'd4: begin
        w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | (32'(s2) << 20) |
            (32'(s1) << 15) | (32'(f3) << 12) | (((im >> 1) & 32'hF) << 8) |
            (((im >> 11) & 32'h1) << 7) | 32'h63;
        rng = (v >= -4096 && v <= 4094 && (im & 32'h1) == 32'h0);
      end
      4'd5: begin
        w = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21) |
            (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12) | (32'(d) << 7) | 32'h6F;
        rng = (v >= -1048576 && v <= 1048574 && (im & 32'h1) == 32'h0);
      end
      4'd6: begin w = ((im & 32'hFFF) << 20) | regs | 32'h67; rng = (v >= -2048 && v <= 2047); end
      4'd7: begin w = (im & 32'hFFFFF000) | (32'(d) << 7) | 32'h37; rng = ((im & 32'hFFF) == 32'h0); end
      4'd8: begin w = (im & 32'hFFFFF000) | (32'(d) << 7) | 32'h17; rng = ((im & 32'hFFF) == 32'h0); end
      4'd15: w = 32'h0;
      default: known = 1'b0;
    endcase
    return {known && (rng || !RANGE_EN), w};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_instr = 32'h0;
    m_addr  = 32'h0;
    m_err   = 1'b0;
  endtask

  // One-entry buffer behaviour: handshake frees the slot and bumps addr; accept fills it.
  task automatic model_edge();
    logic [32:0] e;
    bit acc;
    bit hs;
    e   = ref_encode(kind, funct3, funct7b5, rd, rs1, rs2, imm);
    acc = in_valid && (!m_valid || out_ready);
    hs  = m_valid && out_ready;
    if (hs) begin
      m_valid = 1'b0;
      m_addr  = m_addr + 32'd4;
    end
    if (acc && e[32]) begin
      m_valid = 1'b1;
      m_instr = e[31:0];
    end
    if (clr_err) m_err = 1'b0;
    if (acc && !e[32]) m_err = 1'b1;
  endtask

  task automatic step();
    #1;
    chk("in_ready", in_ready, 32'(!m_valid || out_ready));
    model_edge();
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, 32'(m_valid));
    chk("addr", addr, m_addr);
    chk("error", error, 32'(m_err));
    if (m_valid) chk("instr", instr, m_instr);
  endtask

  task automatic set_in(input logic [3:0] k, input logic [2:0] f3, input logic f7,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [31:0] im);
    kind = k; funct3 = f3; funct7b5 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
    set_in(4'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    model_reset();

    tbl[0]  = '{4'd3,  3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5,        32'h00500093, 1'b0};
    tbl[1]  = '{4'd0,  3'd0, 1'b0, 5'd2, 5'd1, 5'd0, 32'd8,        32'h0080A103, 1'b0};
    tbl[2]  = '{4'd4,  3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0};
    tbl[3]  = '{4'd3,  3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048,     32'h80000093, RANGE_EN};
    tbl[4]  = '{4'd11, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0,        32'h00000000, 1'b1};
    tbl[5]  = '{4'd15, 3'd3, 1'b1, 5'd5, 5'd6, 5'd7, 32'h12345678, 32'h00000000, 1'b0};
    tbl[6]  = '{4'd2,  3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'hFFFFFFFF, 32'h002081B3, 1'b0};
    tbl[7]  = '{4'd2,  3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'h0,        32'h402081B3, 1'b0};
    tbl[8]  = '{4'd7,  3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b0};
    tbl[9]  = '{4'd3,  3'd5, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3,        32'h40315093, 1'b0};
    tbl[10] = '{4'd1,  3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,        32'h0020A423, 1'b0};
    tbl[11] = '{4'd6,  3'd7, 1'b0, 5'd0, 5'd1, 5'd0, 32'd0,        32'h00008067, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_error", error, 32'h0);
    chk("rst_in_ready", in_ready, 32'h1);
    reset = 1'b0;
    model_reset();

    // Fixed encodings; each vector is followed by a drain/clear cycle.
    for (int i = 0; i < 12; i++) begin
      set_in(tbl[i].k, tbl[i].f3, tbl[i].f7, tbl[i].d, tbl[i].s1, tbl[i].s2, tbl[i].im);
      in_valid = 1'b1; out_ready = 1'b1; clr_err = 1'b0;
      step();
      chk($sformatf("tbl%0d_valid", i), out_valid, 32'(!tbl[i].drop));
      chk($sformatf("tbl%0d_error", i), error, 32'(tbl[i].drop));
      if (!tbl[i].drop) chk($sformatf("tbl%0d_instr", i), instr, tbl[i].exp);
      if (i < 2) chk($sformatf("tbl%0d_addr", i), addr, 32'(i * 4));
      in_valid = 1'b0; clr_err = 1'b1;
      step();
      chk($sformatf("tbl%0d_clr", i), error, 32'h0);
      clr_err = 1'b0;
    end

    // Backpressure: entry held stable, no second accept, then back-to-back drain.
    do_reset();
    set_in(4'd3, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    in_valid = 1'b1; out_ready = 1'b0;
    step();
    set_in(4'd0, 3'd0, 1'b0, 5'd2, 5'd1, 5'd0, 32'd8);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp_instr_hold", instr, 32'h00500093);
      chk("bp_addr_hold", addr, 32'h0);
      chk("bp_in_ready", in_ready, 32'h0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_second_instr", instr, 32'h0080A103);
    chk("bp_second_addr", addr, 32'h4);
    in_valid = 1'b0;
    step();
    chk("bp_drained", out_valid, 32'h0);
    chk("bp_final_addr", addr, 32'h8);

    // Error stickiness: clr_err coinciding with a new error keeps error set.
    set_in(4'd11, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    in_valid = 1'b1;
    step();
    clr_err = 1'b1;
    step();
    chk("err_clr_collide", error, 32'h1);
    in_valid = 1'b0;
    step();
    chk("err_cleared", error, 32'h0);
    clr_err = 1'b0;

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 3))
        0: r = 32'($signed(12'(r)));
        1: r = r & 32'h1F;
        2: r = r & 32'hFFFFF000;
        default: ;
      endcase
      set_in(4'($urandom_range(0, 15)), 3'($urandom), 1'($urandom), 5'($urandom),
             5'($urandom), 5'($urandom), r);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clr_err   = ($urandom_range(0, 9) == 0);
      step();
    end
    in_valid = 1'b0; clr_err = 1'b0;

    // Asynchronous reset with a pending entry at addr 8 and error set.
    do_reset();
    set_in(4'd12, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    set_in(4'd3, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    repeat (3) step();
    in_valid = 1'b0; out_ready = 1'b0;
    step();
    chk("mid_pre_valid", out_valid, 32'h1);
    chk("mid_pre_addr", addr, 32'h8);
    chk("mid_pre_error", error, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 32'h0);
    chk("mid_rst_addr", addr, 32'h0);
    chk("mid_rst_error", error, 32'h0);
    chk("mid_rst_instr", instr, 32'h0);
    chk("mid_rst_in_ready", in_ready, 32'h1);
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ignores_input", out_valid, 32'h0);
    reset = 1'b0;
    model_reset();
    set_in(4'd0, 3'd0, 1'b0, 5'd2, 5'd1, 5'd0, 32'd8);
    step();
    chk("post_rst_instr", instr, 32'h0080A103);
    chk("post_rst_addr", addr, 32'h0);
    in_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
